// File: rtl/hex_field_editor_if.sv
// hex_field_editor_if: button, lock and load inputs plus the value/cursor outputs of the field editor.
// master drives the buttons, lock, load and load_val; slave (the editor) returns value, digit_sel and changed.
// Ports: none besides the grouped signals; NDIGITS sets the field width (4*NDIGITS bits).
interface hex_field_editor_if #(
  parameter int NDIGITS = 2
);
  logic                   button_left;
  logic                   button_right;
  logic                   button_up;
  logic                   button_down;
  logic                   lock;
  logic                   load;
  logic [4*NDIGITS-1:0]   load_val;
  logic [4*NDIGITS-1:0]   value;
  logic [NDIGITS-1:0]     digit_sel;
  logic                   changed;

  modport master (
    output button_left, button_right, button_up, button_down, lock, load, load_val,
    input  value, digit_sel, changed
  );

  modport slave (
    input  button_left, button_right, button_up, button_down, lock, load, load_val,
    output value, digit_sel, changed
  );
endinterface

// File: rtl/hex_field_editor.sv
// hex_field_editor: push-button editor for an NDIGITS hex field with cursor, auto-repeat, lock and load.
// Latency: a press sampled at edge k edits at edge k+1; held up/down repeats after HOLD_CYCLES, then every REPEAT_CYCLES.
// Ports: clk, reset (async, active low), bus (slave modport: buttons/lock/load in, value/digit_sel/changed out).
module hex_field_editor #(
  parameter int                   NDIGITS       = 2,
  parameter logic [4*NDIGITS-1:0] RESET_VAL     = 8'h40,
  parameter int                   CURSOR_RST    = 0,
  parameter int                   HOLD_CYCLES   = 50_000_000,
  parameter int                   REPEAT_CYCLES = 10_000_000
) (
  input logic               clk,
  input logic               reset,
  hex_field_editor_if.slave bus
);
  localparam int W       = 4 * NDIGITS;
  localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);

  typedef enum logic [2:0] {IDLE, APPLY, HOLD, REPEAT, WAIT_REL} state_t;
  // Encoding doubles as the bit index into btn, so btn[act_q] is the live level of the act button.
  typedef enum logic [1:0] {ACT_DOWN = 2'd0, ACT_UP = 2'd1, ACT_RIGHT = 2'd2, ACT_LEFT = 2'd3} act_t;

  state_t           state_q, state_d;
  act_t             act_q, act_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       btn, btn_q, press;
  logic             exec;
  logic [W-1:0]     value_q, edited;
  logic [NDIGITS-1:0] sel_q, sel_left, sel_right;
  logic             changed_q;

  assign btn   = {bus.button_left, bus.button_right, bus.button_up, bus.button_down};
  assign press = btn & ~btn_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      act_q   <= ACT_DOWN;
      cnt_q   <= '0;
      btn_q   <= 4'hF;  // a button held through reset must be re-pressed
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      cnt_q   <= cnt_d;
      btn_q   <= btn;
    end
  end

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    cnt_d   = cnt_q;
    exec    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|press) begin
          state_d = APPLY;
          if (press[3])      act_d = ACT_LEFT;
          else if (press[2]) act_d = ACT_RIGHT;
          else if (press[1]) act_d = ACT_UP;
          else               act_d = ACT_DOWN;
        end
      end
      APPLY: begin
        exec = 1'b1;
        if (act_q == ACT_UP || act_q == ACT_DOWN) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          state_d = WAIT_REL;
        end
      end
      HOLD: begin
        if (!btn[act_q]) begin
          state_d = WAIT_REL;
        end else if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
          exec    = 1'b1;
          cnt_d   = '0;
          state_d = REPEAT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      REPEAT: begin
        if (!btn[act_q]) begin
          state_d = WAIT_REL;
        end else if (cnt_q == CW'(REPEAT_CYCLES - 1)) begin
          exec  = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_REL: begin
        if (btn == 4'h0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-digit wrap without carry, and cursor rotation that also holds for NDIGITS=1.
  always_comb begin
    edited    = value_q;
    sel_left  = '0;
    sel_right = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (sel_q[i]) begin
        edited[4*i +: 4] = (act_q == ACT_UP) ? value_q[4*i +: 4] + 4'd1 : value_q[4*i +: 4] - 4'd1;
      end
      sel_left[(i + 1) % NDIGITS] = sel_q[i];
      sel_right[i]                = sel_q[(i + 1) % NDIGITS];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q   <= RESET_VAL;
      sel_q     <= NDIGITS'(1) << CURSOR_RST;
      changed_q <= 1'b0;
    end else begin
      // load wins over an edit in the same cycle; a cursor move still happens.
      if (bus.load) begin
        value_q   <= bus.load_val;
        changed_q <= 1'b1;
      end else if (exec && (act_q == ACT_UP || act_q == ACT_DOWN) && !bus.lock) begin
        value_q   <= edited;
        changed_q <= 1'b1;
      end else begin
        changed_q <= 1'b0;
      end
      if (exec && act_q == ACT_LEFT)  sel_q <= sel_left;
      if (exec && act_q == ACT_RIGHT) sel_q <= sel_right;
    end
  end

  assign bus.value     = value_q;
  assign bus.digit_sel = sel_q;
  assign bus.changed   = changed_q;
endmodule

// File: tb/tb_hex_field_editor.sv
// tb_hex_field_editor: directed bench for hex_field_editor with an edge-timeline model checked every cycle.
// Inputs change on the falling edge; outputs are compared 1 time unit after each rising edge.
// Literal expectations at key points pin the model against hand-computed values.
module tb_hex_field_editor;
  localparam int HOLD   = 4;
  localparam int REPEAT = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  hex_field_editor_if #(.NDIGITS(2)) bus ();

  hex_field_editor #(
    .NDIGITS(2), .RESET_VAL(8'h40), .CURSOR_RST(0),
    .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REPEAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: edits are scheduled by edge arithmetic from the press edge k:
  // k+1, then k+1+HOLD, then every REPEAT edges, while the button stays high.
  int         t_edge;
  int         m_k;
  int         m_phase;   // 0 waiting for press, 1 press seen, 2 timed up/down, 3 waiting for release
  int         m_act;     // bit index: 0 down, 1 up, 2 right, 3 left
  logic [3:0] m_prev;
  logic [7:0] e_val;
  logic [1:0] e_sel;
  logic       e_chg;

  always @(posedge clk) begin
    logic [3:0] b, p;
    bit         ex;
    int         d, di;
    b  = {bus.button_left, bus.button_right, bus.button_up, bus.button_down};
    ex = 0;
    if (!reset) begin
      t_edge = 0; m_phase = 0; m_prev = 4'hF;
      e_val = 8'h40; e_sel = 2'b01; e_chg = 1'b0;
    end else begin
      t_edge++;
      case (m_phase)
        0: begin
          p = b & ~m_prev;
          if (p != 0) begin
            m_act = p[3] ? 3 : p[2] ? 2 : p[1] ? 1 : 0;
            m_k = t_edge;
            m_phase = 1;
          end
        end
        1: begin
          ex = 1;
          m_phase = (m_act < 2) ? 2 : 3;
        end
        2: begin
          if (!b[m_act]) m_phase = 3;
          else begin
            d = t_edge - m_k - 1;
            if (d == HOLD || (d > HOLD && (d - HOLD) % REPEAT == 0)) ex = 1;
          end
        end
        default: if (b == 4'h0) m_phase = 0;
      endcase
      e_chg = 1'b0;
      di = e_sel[1] ? 1 : 0;
      if (bus.load) begin
        e_val = bus.load_val;
        e_chg = 1'b1;
      end else if (ex && m_act < 2 && !bus.lock) begin
        if (m_act == 1) e_val[4*di +: 4] = e_val[4*di +: 4] + 4'd1;
        else            e_val[4*di +: 4] = e_val[4*di +: 4] - 4'd1;
        e_chg = 1'b1;
      end
      if (ex && m_act >= 2) e_sel = {e_sel[0], e_sel[1]};
      m_prev = b;
    end
    #1;
    check("value", 32'(bus.value), 32'(e_val));
    check("digit_sel", 32'(bus.digit_sel), 32'(e_sel));
    check("changed", 32'(bus.changed), 32'(e_chg));
  end

  task automatic set_btns(input logic [3:0] b);
    {bus.button_left, bus.button_right, bus.button_up, bus.button_down} = b;
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-edge tap, then enough idle edges for the editor to return to idle.
  task automatic tap(input logic [3:0] b);
    set_btns(b);
    ticks(1);
    set_btns(4'h0);
    ticks(3);
  endtask

  localparam logic [3:0] B_L = 4'b1000, B_R = 4'b0100, B_U = 4'b0010, B_D = 4'b0001;

  initial begin
    set_btns(4'h0);
    bus.lock = 1'b0; bus.load = 1'b0; bus.load_val = 8'h00;
    ticks(2);
    reset = 1'b1;
    ticks(2);

    // 1: single up tap
    set_btns(B_U);
    ticks(1);
    set_btns(4'h0);
    check("t1 before edit", 32'(bus.value), 32'h40);
    ticks(1);
    check("t1 value", 32'(bus.value), 32'h41);
    check("t1 changed", 32'(bus.changed), 32'h1);
    check("t1 sel", 32'(bus.digit_sel), 32'h1);
    ticks(1);
    check("t1 changed drop", 32'(bus.changed), 32'h0);
    ticks(2);

    // 2: cursor to MSD, increment up to wrap
    reset = 1'b0; ticks(1); reset = 1'b1; ticks(1);
    tap(B_L);
    check("t2 sel msd", 32'(bus.digit_sel), 32'h2);
    for (int i = 0; i < 8; i++) tap(B_U);
    check("t2 value C0", 32'(bus.value), 32'hC0);
    for (int i = 0; i < 3; i++) tap(B_U);
    check("t2 value F0", 32'(bus.value), 32'hF0);
    tap(B_U);
    check("t2 wrap 00", 32'(bus.value), 32'h00);
    tap(B_L);
    check("t2 sel wrap", 32'(bus.digit_sel), 32'h1);

    // 3: load 40, hold down on LSD through four edits
    bus.load = 1'b1; bus.load_val = 8'h40;
    ticks(1);
    bus.load = 1'b0;
    ticks(1);
    set_btns(B_D);
    ticks(10);
    set_btns(4'h0);
    ticks(4);
    check("t3 held down", 32'(bus.value), 32'h4C);
    ticks(4);
    check("t3 no edit after release", 32'(bus.value), 32'h4C);

    // 4: simultaneous left+up, then up during release wait
    set_btns(B_L | B_U);
    ticks(1);
    set_btns(B_L);
    ticks(1);
    set_btns(B_L | B_U);
    ticks(2);
    set_btns(4'h0);
    ticks(3);
    check("t4 sel", 32'(bus.digit_sel), 32'h2);
    check("t4 value", 32'(bus.value), 32'h4C);

    // 5: locked tap, then load colliding with an up APPLY
    bus.lock = 1'b1;
    tap(B_U);
    bus.lock = 1'b0;
    check("t5 locked", 32'(bus.value), 32'h4C);
    set_btns(B_U);
    ticks(1);
    set_btns(4'h0);
    bus.load = 1'b1; bus.load_val = 8'hA5;
    ticks(1);
    bus.load = 1'b0;
    ticks(3);
    check("t5 load wins", 32'(bus.value), 32'hA5);

    // 6: reset mid-repeat with up held
    set_btns(B_U);
    ticks(8);
    reset = 1'b0;
    #1;
    check("t6 async reset", 32'(bus.value), 32'h40);
    ticks(2);
    reset = 1'b1;
    ticks(8);
    check("t6 held across reset", 32'(bus.value), 32'h40);
    set_btns(4'h0);
    ticks(2);
    tap(B_U);
    check("t6 fresh press", 32'(bus.value), 32'h41);
    ticks(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
